ram_bus_ctrl: RTL and testbench

RAM_BUS_CTRL -- requirements
Module: ram_bus_ctrl

---
 rtl/ram_bus_ctrl.sv | 137 +++++++++++++
 tb/tb_ram_bus_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ram_bus_ctrl
// Description : Host-to-async-RAM controller driving a shared tri-state data
//               bus. Writes run setup/pulse/hold, reads run a turnaround
//               cycle then two enable cycles, and each transaction ends with
//               a one-cycle done pulse. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_bus_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  ready_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic                  ram_cs_o,
    output logic                  ram_we_o,
    output logic                  ram_re_o,
    output logic [DATA_WIDTH-1:0] bus_data_o,
    output logic                  bus_oe_o,
    input  logic [DATA_WIDTH-1:0] bus_data_i
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WR_SETUP  = 3'd1,
        WR_PULSE  = 3'd2,
        WR_HOLD   = 3'd3,
        RD_ADDR   = 3'd4,
        RD_WAIT   = 3'd5,
        RD_SAMPLE = 3'd6,
        DONE      = 3'd7
    } state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    r_ready;
    logic                    r_done;
    logic                    r_cs;
    logic                    r_we;
    logic                    r_re;
    logic                    r_oe;
    logic [ADDR_WIDTH-1:0]   r_ram_addr;
    logic [DATA_WIDTH-1:0]   r_bus_data;

    state_t                  w_next;
    logic                    w_accept;
    logic [ADDR_WIDTH-1:0]   w_cap_addr;
    logic [DATA_WIDTH-1:0]   w_cap_wdata;
    logic                    w_nxt_cs;
    logic                    w_nxt_oe;

    // A request is only taken while idle; the operation type is carried by
    // the path the state machine takes, so no separate we flag is kept.
    assign w_accept    = (r_state == IDLE) && req_i;
    assign w_cap_addr  = w_accept ? addr_i  : r_addr;
    assign w_cap_wdata = w_accept ? wdata_i : r_wdata;

    // Next-state sequencing: fixed one-cycle-per-state walks through each
    // sequence, converging on DONE and then IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      w_next = req_i ? (we_i ? WR_SETUP : RD_ADDR) : IDLE;
            WR_SETUP:  w_next = WR_PULSE;
            WR_PULSE:  w_next = WR_HOLD;
            WR_HOLD:   w_next = DONE;
            RD_ADDR:   w_next = RD_WAIT;
            RD_WAIT:   w_next = RD_SAMPLE;
            RD_SAMPLE: w_next = DONE;
            DONE:      w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    assign w_nxt_cs = (w_next != IDLE) && (w_next != DONE);
    assign w_nxt_oe = (w_next == WR_SETUP) || (w_next == WR_PULSE) ||
                      (w_next == WR_HOLD);

    // State, captured request and registered Moore outputs for the state
    // being entered; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
            r_cs       <= 1'b0;
            r_we       <= 1'b0;
            r_re       <= 1'b0;
            r_oe       <= 1'b0;
            r_ram_addr <= '0;
            r_bus_data <= '0;
        end else begin
            r_state    <= w_next;
            r_addr     <= w_cap_addr;
            r_wdata    <= w_cap_wdata;
            if (r_state == RD_SAMPLE) begin
                r_rdata <= bus_data_i;
            end
            r_ready    <= (w_next == IDLE);
            r_done     <= (w_next == DONE);
            r_cs       <= w_nxt_cs;
            r_we       <= (w_next == WR_PULSE);
            r_re       <= (w_next == RD_WAIT) || (w_next == RD_SAMPLE);
            r_oe       <= w_nxt_oe;
            // Address is only presented while the chip is selected, and bus
            // data is zeroed whenever the drivers are disabled.
            r_ram_addr <= w_nxt_cs ? w_cap_addr : '0;
            r_bus_data <= w_nxt_oe ? w_cap_wdata : '0;
        end
    end

    assign ready_o    = r_ready;
    assign done_o     = r_done;
    assign rdata_o    = r_rdata;
    assign ram_addr_o = r_ram_addr;
    assign ram_cs_o   = r_cs;
    assign ram_we_o   = r_we;
    assign ram_re_o   = r_re;
    assign bus_data_o = r_bus_data;
    assign bus_oe_o   = r_oe;

endmodule
`default_nettype wire

// File: tb/tb_ram_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_bus_ctrl
// Description : Self-checking bench for ram_bus_ctrl with a RAM model on the
//               shared bus, a bus-rule monitor and a transaction scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_bus_ctrl;

    logic       clk;
    logic       rst_n;
    logic       req_i;
    logic       we_i;
    logic [3:0] addr_i;
    logic [7:0] wdata_i;
    logic       ready_o;
    logic       done_o;
    logic [7:0] rdata_o;
    logic [3:0] ram_addr_o;
    logic       ram_cs_o;
    logic       ram_we_o;
    logic       ram_re_o;
    logic [7:0] bus_data_o;
    logic       bus_oe_o;
    logic [7:0] bus_data_i;

    ram_bus_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req_i),
        .we_i       (we_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .ready_o    (ready_o),
        .done_o     (done_o),
        .rdata_o    (rdata_o),
        .ram_addr_o (ram_addr_o),
        .ram_cs_o   (ram_cs_o),
        .ram_we_o   (ram_we_o),
        .ram_re_o   (ram_re_o),
        .bus_data_o (bus_data_o),
        .bus_oe_o   (bus_oe_o),
        .bus_data_i (bus_data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model and bus resolution (idle bus reads as zero).
    logic [7:0] ram [16];
    assign bus_data_i = bus_oe_o ? bus_data_o :
                        ((ram_cs_o && ram_re_o) ? ram[ram_addr_o] : 8'h00);
    always @(posedge clk) begin
        if (ram_cs_o && ram_we_o) ram[ram_addr_o] <= bus_data_i;
    end

    int cyc;
    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor: contention, turnaround gap, zero data while disabled.
    int  n_done, n_conflict, n_gap, n_oedata;
    logic prev_re;
    initial begin
        n_done = 0; n_conflict = 0; n_gap = 0; n_oedata = 0; prev_re = 1'b0; cyc = 0;
    end
    always @(negedge clk) begin
        if (done_o) n_done++;
        if (bus_oe_o && ram_re_o) n_conflict++;
        if (prev_re && !ram_re_o && bus_oe_o) n_gap++;
        if (!bus_oe_o && bus_data_o != 8'h00) n_oedata++;
        prev_re = ram_re_o;
    end

    typedef struct packed {
        logic       we;
        logic [3:0] addr;
        logic [7:0] data;
    } exp_t;
    exp_t       sb_q[$];
    logic [7:0] mem_model [16];
    int         n_cmp, n_err;
    int         accept_cyc;

    // Issue one transaction from a negedge and check every cycle of it.
    task automatic txn(input logic w, input logic [3:0] a, input logic [7:0] d,
                       input bit hold, input bit toggle);
        int          guard;
        exp_t        e;
        logic [17:0] obs, expv;
        logic        ecs, ewe, ere, eoe;
        req_i = 1'b1; we_i = w; addr_i = a; wdata_i = d;
        guard = 0;
        while (!ready_o && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        n_cmp++;
        if (!ready_o) begin
            n_err++;
            $display("FAIL accept_timeout: ready_o=%0b required 1", ready_o);
            req_i = 1'b0;
            return;
        end
        accept_cyc = cyc + 1;
        e.we = w; e.addr = a; e.data = w ? d : mem_model[a];
        if (w) mem_model[a] = d;
        sb_q.push_back(e);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ecs = (i < 3);
            ewe = w && (i == 1);
            ere = !w && (i == 1 || i == 2);
            eoe = w && (i < 3);
            expv = {1'b0, (i == 3), ecs, ewe, ere, eoe,
                    (ecs ? a : 4'h0), (eoe ? d : 8'h00)};
            obs  = {ready_o, done_o, ram_cs_o, ram_we_o, ram_re_o, bus_oe_o,
                    ram_addr_o, bus_data_o};
            n_cmp++;
            if (obs !== expv) begin
                n_err++;
                $display("FAIL seq_cycle%0d we=%0b addr=%h: got %h required %h",
                         i, w, a, obs, expv);
            end
            if (i == 3) begin
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_err++;
                    $display("FAIL scoreboard_empty: got 0 entries required 1");
                end else begin
                    e = sb_q.pop_front();
                    if (e.we && ram[e.addr] !== e.data) begin
                        n_err++;
                        $display("FAIL ram_write @%h: got %h required %h",
                                 e.addr, ram[e.addr], e.data);
                    end else if (!e.we && rdata_o !== e.data) begin
                        n_err++;
                        $display("FAIL rdata @%h: got %h required %h",
                                 e.addr, rdata_o, e.data);
                    end
                end
            end
            if (toggle) begin
                req_i = (i % 2 == 0) && (i != 3);
                we_i  = ~w;
                addr_i = ~a;
            end else if (!hold) begin
                req_i = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        logic [17:0] obs;
        rst_n = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
        #1 rst_n = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        obs = {ready_o, done_o, ram_cs_o, ram_we_o, ram_re_o, bus_oe_o,
               ram_addr_o, bus_data_o};
        n_cmp++;
        if (obs !== 18'h20000) begin
            n_err++;
            $display("FAIL reset_outputs: got %h required %h", obs, 18'h20000);
        end
        n_cmp++;
        if (rdata_o !== 8'h00) begin
            n_err++;
            $display("FAIL reset_rdata: got %h required 00", rdata_o);
        end
    endtask

    task automatic test_write_read();
        txn(1'b1, 4'h3, 8'hA5, 1'b0, 1'b0);
        @(negedge clk);
        txn(1'b0, 4'h3, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_patterns();
        logic [3:0] a;
        logic [7:0] d;
        for (int k = 0; k < 6; k++) begin
            a = 4'($urandom_range(0, 15));
            d = 8'($urandom);
            @(negedge clk);
            txn(1'b1, a, d, 1'b0, 1'b0);
            @(negedge clk);
            txn(1'b0, a, 8'h00, 1'b0, 1'b0);
        end
        @(negedge clk);
        txn(1'b1, 4'hF, 8'hFF, 1'b0, 1'b0);
        @(negedge clk);
        txn(1'b0, 4'hF, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int c0;
        @(negedge clk);
        txn(1'b1, 4'h7, 8'h5A, 1'b1, 1'b0);
        c0 = accept_cyc;
        txn(1'b0, 4'h7, 8'h00, 1'b0, 1'b0);
        n_cmp++;
        if (accept_cyc - c0 != 5) begin
            n_err++;
            $display("FAIL b2b_spacing: got %0d edges required 5", accept_cyc - c0);
        end
    endtask

    task automatic test_req_toggle();
        int d0;
        @(negedge clk);
        d0 = n_done;
        txn(1'b0, 4'h3, 8'h00, 1'b0, 1'b1);
        req_i = 1'b0;
        @(negedge clk); @(negedge clk); @(negedge clk);
        n_cmp++;
        if (n_done - d0 != 1) begin
            n_err++;
            $display("FAIL toggle_done_count: got %0d required 1", n_done - d0);
        end
    endtask

    task automatic test_reset_abort();
        int          d0;
        int          guard;
        logic [16:0] obs;
        @(negedge clk);
        txn(1'b1, 4'h5, 8'h11, 1'b0, 1'b0);
        @(negedge clk);
        d0 = n_done;
        req_i = 1'b1; we_i = 1'b1; addr_i = 4'h5; wdata_i = 8'hEE;
        guard = 0;
        while (!ready_o && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        req_i = 1'b0;
        @(posedge clk);
        #2;
        n_cmp++;
        if (ram_we_o !== 1'b1) begin
            n_err++;
            $display("FAIL abort_pulse_reached: ram_we_o=%0b required 1", ram_we_o);
        end
        rst_n = 1'b0;
        #1;
        obs = {ready_o, done_o, ram_cs_o, ram_we_o, ram_re_o, bus_oe_o,
               ram_addr_o, bus_data_o[6:0]};
        n_cmp++;
        if (obs !== 17'h10000 || bus_data_o[7] !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset_outputs: got %h/%0b required 10000/0",
                     obs, bus_data_o[7]);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (n_done != d0) begin
            n_err++;
            $display("FAIL abort_no_done: got %0d pulses required 0", n_done - d0);
        end
        n_cmp++;
        if (ram[5] !== 8'h11) begin
            n_err++;
            $display("FAIL abort_ram_intact: got %h required 11", ram[5]);
        end
        txn(1'b0, 4'h5, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_bus_rules();
        @(negedge clk); @(negedge clk);
        n_cmp++;
        if (n_conflict != 0) begin
            n_err++;
            $display("FAIL bus_contention: got %0d cycles required 0", n_conflict);
        end
        n_cmp++;
        if (n_gap != 0) begin
            n_err++;
            $display("FAIL turnaround_gap: got %0d violations required 0", n_gap);
        end
        n_cmp++;
        if (n_oedata != 0) begin
            n_err++;
            $display("FAIL data_when_disabled: got %0d cycles required 0", n_oedata);
        end
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_leftover: got %0d required 0", sb_q.size());
        end
    endtask

    initial begin
        n_cmp = 0; n_err = 0; accept_cyc = 0;
        for (int i = 0; i < 16; i++) mem_model[i] = 8'h00;
        test_reset();
        test_write_read();
        test_patterns();
        test_back_to_back();
        test_req_toggle();
        test_reset_abort();
        test_bus_rules();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
